psram_rd_capture: RTL
=====================

PSRAM_RD_CAPTURE -- requirements
Module: psram_rd_capture

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth for DQS and IO inputs (min 2).
REQ-002 Parameter TOUT_WIDTH, default 8, width of the timeout counter and cap_tout_i.
REQ-003 clk_i  in  1  single block clock, rising-edge only.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 cap_start_i  in  1  one-cycle pulse that opens a read-capture window.
REQ-006 cap_len_i  in  3  bytes to capture minus 1 (0 = 1 byte, 7 = 8 bytes).
REQ-007 cap_tout_i  in  TOUT_WIDTH  max clk cycles between DQS edges; 0 disables timeout.
REQ-008 cap_busy_o  out  1  high whenever state is not IDLE.
REQ-009 psram_dqs_in_i  in  1  raw DQS from pad, asynchronous to clk_i.
REQ-010 psram_io_in_i  in  8  raw DQ from pad, asynchronous to clk_i.
REQ-011 rd_valid_o  out  1  captured word available.
REQ-012 rd_ready_i  in  1  consumer accepts word.
REQ-013 rd_data_o  out  64  captured word; first byte in [63:56], uncaptured bytes zero.
REQ-014 rd_err_o  out  1  qualifies rd_valid_o; window ended by timeout.
REQ-015 cfg_data_o  out  8  first captured byte (register-read result), equals rd_data_o[63:56].

Function
REQ-016 States: IDLE, ARMED (window open, no edge yet), CAPT (>=1 byte captured), DONE (holding result).
REQ-017 IDLE -> ARMED on cap_start_i; byte counter, data register, timeout counter and rd_err_o cleared on that edge.
REQ-018 cap_start_i in ARMED, CAPT or DONE is ignored.
REQ-019 DQS and IO each pass through SYNC_STAGES flops; one extra DQS flop provides edge detection on synced DQS.
REQ-020 Both rising and falling synced-DQS edges are DDR beats; each beat in ARMED/CAPT writes the IO byte synced in the same stage as the DQS sample into data byte [63-8n:56-8n], n = byte counter.
REQ-021 With SYNC_STAGES=2, a byte is written on the 3rd clk edge after the first clk edge sampling the new DQS level.
REQ-022 ARMED -> CAPT on first beat; when beat n equals cap_len_i, state -> DONE on the same edge (either from ARMED or CAPT).
REQ-023 DQS edges in IDLE or DONE are ignored and do not change data.
REQ-024 Timeout counter increments every cycle in ARMED/CAPT, clears on each beat; on reaching cap_tout_i (nonzero) state -> DONE with rd_err_o=1, partial data kept.
REQ-025 rd_valid_o = (state == DONE); rd_data_o, rd_err_o, cfg_data_o stable while rd_valid_o high.
REQ-026 DONE -> IDLE on rd_valid_o && rd_ready_i; rd_ready_i outside DONE has no effect.
REQ-027 A beat and timeout in the same cycle: beat wins, timeout counter clears.
REQ-028 Byte counter is 3 bits, never wraps: DONE is entered at most when counter equals 7.
REQ-029 cap_len_i and cap_tout_i are sampled on the cap_start_i edge and held internally for the window.

Reset
REQ-030 On rst_i: state IDLE, counters 0, data register 0, synchronizer flops 0.
REQ-031 Output reset values: cap_busy_o=0, rd_valid_o=0, rd_err_o=0, rd_data_o=0, cfg_data_o=0.
REQ-032 rst_i mid-window aborts immediately; no rd_valid_o is produced for the aborted window.

Structure
REQ-033 State encoding (PSRAM_CAP_IDLE/ARMED/CAPT/DONE) and default SYNC_STAGES live in the shared psram define package.
REQ-034 One sub-module psram_cap_sync: parameterised SYNC_STAGES flop chain, async active-high reset, used for DQS and IO.
REQ-035 No latches, no clocking by DQS; all logic in clk_i domain.

Verification
REQ-036 start, len=7, tout=20, 8 DQS edges 4 cycles apart with bytes 11..88 -> rd_valid_o, rd_data_o=0x1122334455667788, rd_err_o=0.
REQ-037 start, len=1, 2 edges bytes A5,5A -> rd_data_o=0xA55A000000000000, cfg_data_o=0xA5.
REQ-038 start, len=7, tout=10, 3 edges then DQS static -> DONE after 10 idle cycles, rd_err_o=1, top 3 bytes valid, rest 0.
REQ-039 rd_ready_i held low 50 cycles in DONE with extra DQS edges and cap_start_i -> data unchanged, rd_valid_o stays high; ready -> IDLE next cycle.
REQ-040 rst_i asserted after 4 of 8 beats -> all outputs 0 immediately; next window with len=0 byte 0x3C -> rd_data_o=0x3C00000000000000.
REQ-041 tout=0, no edges for 1000 cycles -> remains ARMED, cap_busy_o=1, rd_valid_o=0.

Source files
------------

// File: rtl/psram_rd_capture_pkg.sv
// psram_rd_capture_pkg: shared state encoding, default sync depth and byte-lane helper for the PSRAM read capture.
package psram_rd_capture_pkg;

    typedef enum logic [1:0] {
        PSRAM_CAP_IDLE,
        PSRAM_CAP_ARMED,
        PSRAM_CAP_CAPT,
        PSRAM_CAP_DONE
    } psram_cap_state_e;

    localparam int PSRAM_SYNC_STAGES_DEF = 2;

    // Byte n lands at [63-8n:56-8n]; 8*(7-n) is just ~n shifted left by 3.
    function automatic logic [5:0] byte_lsb(input logic [2:0] n);
        return {~n, 3'b000};
    endfunction

endpackage

// File: rtl/psram_rd_capture_if.sv
// psram_rd_capture_if: capture control and read-result handshake between controller and capture block.
interface psram_rd_capture_if #(parameter int TOUT_WIDTH = 8);

    logic                  cap_start_i;
    logic [2:0]            cap_len_i;
    logic [TOUT_WIDTH-1:0] cap_tout_i;
    logic                  cap_busy_o;
    logic                  rd_valid_o;
    logic                  rd_ready_i;
    logic [63:0]           rd_data_o;
    logic                  rd_err_o;
    logic [7:0]            cfg_data_o;

    modport master (
        output cap_start_i, cap_len_i, cap_tout_i, rd_ready_i,
        input  cap_busy_o, rd_valid_o, rd_data_o, rd_err_o, cfg_data_o
    );

    modport slave (
        input  cap_start_i, cap_len_i, cap_tout_i, rd_ready_i,
        output cap_busy_o, rd_valid_o, rd_data_o, rd_err_o, cfg_data_o
    );

endinterface

// File: rtl/psram_cap_sync.sv
// psram_cap_sync: STAGES-deep flop chain bringing pad signals into the clk_i domain.
module psram_cap_sync #(
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] s_q, s_d;

    always_comb s_d = {s_q[STAGES-2:0], d_i};

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) s_q <= '0;
        else       s_q <= s_d;

    assign q_o = s_q[STAGES-1];

endmodule

// File: rtl/psram_rd_capture.sv
// psram_rd_capture: samples DDR read bytes on both DQS edges in the clk_i domain,
// with beat count limit, inter-edge timeout and a valid/ready result hold.
module psram_rd_capture
    import psram_rd_capture_pkg::*;
#(
    parameter int SYNC_STAGES = PSRAM_SYNC_STAGES_DEF,
    parameter int TOUT_WIDTH  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                psram_dqs_in_i,
    input  logic [7:0]          psram_io_in_i,
    psram_rd_capture_if.slave   bus
);

    psram_cap_state_e      state_q, state_d;
    logic [2:0]            cnt_q, cnt_d, len_q, len_d;
    logic [TOUT_WIDTH-1:0] lim_q, lim_d, tout_q, tout_d;
    logic [63:0]           data_q, data_d;
    logic                  err_q, err_d, dqs_prev_q, dqs_prev_d;
    logic                  dqs_s, beat, open;
    logic [7:0]            io_s;

    // IO uses the same depth as DQS so the byte seen with an edge is the one launched with it.
    psram_cap_sync #(.STAGES(SYNC_STAGES), .W(1)) u_dqs_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(psram_dqs_in_i), .q_o(dqs_s)
    );
    psram_cap_sync #(.STAGES(SYNC_STAGES), .W(8)) u_io_sync (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(psram_io_in_i), .q_o(io_s)
    );

    assign beat = dqs_s ^ dqs_prev_q;
    assign open = (state_q == PSRAM_CAP_ARMED) || (state_q == PSRAM_CAP_CAPT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        lim_d      = lim_q;
        tout_d     = tout_q;
        data_d     = data_q;
        err_d      = err_q;
        dqs_prev_d = dqs_s;
        if (state_q == PSRAM_CAP_IDLE && bus.cap_start_i) begin
            state_d = PSRAM_CAP_ARMED;
            cnt_d   = '0;
            data_d  = '0;
            tout_d  = '0;
            err_d   = 1'b0;
            len_d   = bus.cap_len_i;
            lim_d   = bus.cap_tout_i;
        end else if (open && beat) begin
            data_d[byte_lsb(cnt_q) +: 8] = io_s;
            tout_d  = '0;
            state_d = (cnt_q == len_q) ? PSRAM_CAP_DONE : PSRAM_CAP_CAPT;
            cnt_d   = (cnt_q == len_q) ? cnt_q : cnt_q + 3'd1;
        end else if (open) begin
            tout_d = TOUT_WIDTH'(tout_q + 1'b1);
            if (lim_q != '0 && tout_d == lim_q) begin
                state_d = PSRAM_CAP_DONE;
                err_d   = 1'b1;
            end
        end else if (state_q == PSRAM_CAP_DONE && bus.rd_ready_i) begin
            state_d = PSRAM_CAP_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q    <= PSRAM_CAP_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            lim_q      <= '0;
            tout_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            dqs_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            lim_q      <= lim_d;
            tout_q     <= tout_d;
            data_q     <= data_d;
            err_q      <= err_d;
            dqs_prev_q <= dqs_prev_d;
        end

    assign bus.cap_busy_o = state_q != PSRAM_CAP_IDLE;
    assign bus.rd_valid_o = state_q == PSRAM_CAP_DONE;
    assign bus.rd_data_o  = data_q;
    assign bus.rd_err_o   = err_q;
    assign bus.cfg_data_o = data_q[63:56];

endmodule
